// File: rtl/fp_seq_pkg.sv
// Shared definitions for the FP operation sequencer: FSM encoding, ALU op codes,
// IEEE-754 special values and result flag positions.
package fp_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_LOAD     = 3'd1;
  localparam state_t S_WAIT     = 3'd2;
  localparam state_t S_CLASSIFY = 3'd3;
  localparam state_t S_ISSUE    = 3'd4;
  localparam state_t S_WAIT_RES = 3'd5;
  localparam state_t S_EMIT     = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int FLAG_BYPASS  = 0;
  localparam int FLAG_TIMEOUT = 1;
  localparam int FLAG_NAN     = 2;

  function automatic logic [31:0] signed_inf(input logic sign);
    return POS_INF | {sign, 31'd0};
  endfunction

  function automatic logic [2:0] pack_flags(input logic nan, input logic tmo, input logic byp);
    logic [2:0] f;
    f               = '0;
    f[FLAG_NAN]     = nan;
    f[FLAG_TIMEOUT] = tmo;
    f[FLAG_BYPASS]  = byp;
    return f;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision special-value decoder.
// Denormals are reported as neither zero nor special.
module fp_classify (
  input  logic [31:0] operand,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        sign
);

  logic       exp_max;
  logic       man_zero;

  assign exp_max  = (operand[30:23] == 8'hFF);
  assign man_zero = (operand[22:0] == 23'd0);

  assign is_nan  = exp_max & ~man_zero;
  assign is_inf  = exp_max & man_zero;
  assign is_zero = (operand[30:23] == 8'h00) & man_zero;
  assign sign    = operand[31];

endmodule

// File: rtl/fp_op_sequencer.sv
// Fetches operand pairs, then issues ADD/SUB/MUL/DIV per pair to the FP ALU and
// emits one tagged result per op. Optional special-value bypass: SPECIAL_BYPASS_EN.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | one-cycle load_data pulse to operand memory
// WAIT     | LOAD_WAIT cycles of fetch latency, capture A/B on the last
// CLASSIFY | register special-value flags of A/B, reset op to ADD
// ISSUE    | valid/ready request to the ALU (or bypass)
// WAIT_RES | wait for ALU result strobe or timeout
// EMIT     | one-cycle result strobe, advance op/pair
module fp_op_sequencer
  import fp_seq_pkg::*;
#(
  parameter int PAIR_COUNT = 12,
  parameter int LOAD_WAIT  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        load_data,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_valid,
  input  logic        alu_ready,
  input  logic [31:0] alu_res,
  input  logic        alu_res_valid,
  output logic [31:0] res_out,
  output logic [1:0]  res_op,
  output logic [3:0]  res_idx,
  output logic [2:0]  res_flags,
  output logic        res_valid,
  output logic        busy,
  output logic        done
);

`ifdef SPECIAL_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  state_t      state_q;
  logic [3:0]  pair_q;
  logic [1:0]  op_q;
  logic [3:0]  wait_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [31:0] a_q, b_q, res_q;
  logic [2:0]  flags_q;
  logic        done_q;

  logic a_nan, a_inf, a_zero, a_sign;
  logic b_nan, b_inf, b_zero, b_sign;
  logic a_nan_q, a_inf_q, a_zero_q, a_sign_q;
  logic b_nan_q, b_inf_q, b_zero_q, b_sign_q;

  logic        nan_any;
  logic        byp_raw;
  logic        byp_hit;
  logic [31:0] byp_val;
  logic        b_sign_eff;

  fp_classify u_cls_a (
    .operand (a_q),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .is_zero (a_zero),
    .sign    (a_sign)
  );

  fp_classify u_cls_b (
    .operand (b_q),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .is_zero (b_zero),
    .sign    (b_sign)
  );

  assign nan_any = a_nan_q | b_nan_q;

  // SUB is treated as ADD with B negated so inf-inf is caught in the effective sense.
  always_comb begin
    byp_raw    = 1'b0;
    byp_val    = QNAN;
    b_sign_eff = b_sign_q ^ (op_q == OP_SUB);
    if (a_nan_q || b_nan_q) begin
      byp_raw = 1'b1;
    end else if ((op_q == OP_ADD || op_q == OP_SUB) && (a_inf_q || b_inf_q)) begin
      byp_raw = 1'b1;
      if (a_inf_q && b_inf_q && (a_sign_q != b_sign_eff))
        byp_val = QNAN;
      else if (a_inf_q)
        byp_val = signed_inf(a_sign_q);
      else
        byp_val = signed_inf(b_sign_eff);
    end else if (op_q == OP_DIV && b_zero_q) begin
      byp_raw = 1'b1;
      byp_val = a_zero_q ? QNAN : signed_inf(a_sign_q ^ b_sign_q);
    end
  end

  assign byp_hit = BYPASS_EN & byp_raw;

  assign load_data = (state_q == S_LOAD);
  assign alu_valid = (state_q == S_ISSUE) & ~byp_hit;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign res_valid = (state_q == S_EMIT);
  assign res_out   = res_q;
  assign res_op    = op_q;
  assign res_idx   = pair_q;
  assign res_flags = flags_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pair_q     <= '0;
      op_q       <= '0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      a_nan_q    <= 1'b0;
      a_inf_q    <= 1'b0;
      a_zero_q   <= 1'b0;
      a_sign_q   <= 1'b0;
      b_nan_q    <= 1'b0;
      b_inf_q    <= 1'b0;
      b_zero_q   <= 1'b0;
      b_sign_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_LOAD;
        end
        S_LOAD: begin
          wait_cnt_q <= 4'(LOAD_WAIT - 1);
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == '0) begin
            a_q     <= a_in;
            b_q     <= b_in;
            state_q <= S_CLASSIFY;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        S_CLASSIFY: begin
          a_nan_q  <= a_nan;
          a_inf_q  <= a_inf;
          a_zero_q <= a_zero;
          a_sign_q <= a_sign;
          b_nan_q  <= b_nan;
          b_inf_q  <= b_inf;
          b_zero_q <= b_zero;
          b_sign_q <= b_sign;
          op_q     <= OP_ADD;
          state_q  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (byp_hit) begin
            res_q   <= byp_val;
            flags_q <= pack_flags(nan_any, 1'b0, 1'b1);
            state_q <= S_EMIT;
          end else if (alu_ready) begin
            tmo_cnt_q <= 8'(TIMEOUT - 1);
            state_q   <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (alu_res_valid) begin
            res_q   <= alu_res;
            flags_q <= pack_flags(nan_any, 1'b0, 1'b0);
            state_q <= S_EMIT;
          end else if (tmo_cnt_q == '0) begin
            res_q   <= QNAN;
            flags_q <= pack_flags(nan_any, 1'b1, 1'b0);
            state_q <= S_EMIT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 8'd1;
          end
        end
        S_EMIT: begin
          if (op_q != OP_DIV) begin
            op_q    <= op_q + 2'd1;
            state_q <= S_ISSUE;
          end else if (pair_q == 4'(PAIR_COUNT - 1)) begin
            pair_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            pair_q  <= pair_q + 4'd1;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: operand memory and ALU stand-ins with
// random stall/latency, checked against a per-operation reference model.
module tb_fp_op_sequencer;

  localparam logic [31:0] QNAN_C = 32'h7FC00000;
  localparam logic [31:0] INF_C  = 32'h7F800000;
`ifdef SPECIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        load_data;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [31:0] alu_res = '0;
  logic        alu_res_valid = 1'b0;
  logic [31:0] res_out;
  logic [1:0]  res_op;
  logic [3:0]  res_idx;
  logic [2:0]  res_flags;
  logic        res_valid, busy, done;

  fp_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_data(load_data),
    .a_in(a_in), .b_in(b_in), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_res(alu_res),
    .alu_res_valid(alu_res_valid), .res_out(res_out), .res_op(res_op),
    .res_idx(res_idx), .res_flags(res_flags), .res_valid(res_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // {hit, value}: the IEEE result the sequencer should produce without the ALU
  function automatic logic [32:0] ref_special(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
    logic sa, sb;
    sa = a[31];
    sb = b[31] ^ (op == 2'd1);
    if (is_nan(a) || is_nan(b)) return {1'b1, QNAN_C};
    if (op <= 2'd1 && (is_inf(a) || is_inf(b))) begin
      if (is_inf(a) && is_inf(b) && sa != sb) return {1'b1, QNAN_C};
      return {1'b1, INF_C | {(is_inf(a) ? sa : sb), 31'd0}};
    end
    if (op == 2'd3 && is_zero(b))
      return {1'b1, is_zero(a) ? QNAN_C : (INF_C | {a[31] ^ b[31], 31'd0})};
    return {1'b0, 32'd0};
  endfunction

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    return (a * 32'd3) ^ (b + {30'd0, op} * 32'h01010101);
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [31:0] r;
    r        = $urandom;
    r[30:23] = 8'($urandom_range(1, 254));
    return r;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // operand memory: pointer survives reset, data appears after the load pulse
  logic [31:0] mem_a [12];
  logic [31:0] mem_b [12];
  int          ptr = 0;
  int          cur_idx = 0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic        load_prev = 1'b0;

  always @(negedge clk) begin
    if (load_data) begin
      check("load_pulse_single", {31'd0, load_prev}, 32'd0);
      a_in    = mem_a[ptr];
      b_in    = mem_b[ptr];
      cur_a   = mem_a[ptr];
      cur_b   = mem_b[ptr];
      cur_idx = ptr;
      ptr     = (ptr + 1) % 12;
    end
    load_prev = load_data;
  end

  // reference model position
  logic [3:0] m_pair = '0;
  logic [1:0] m_op = '0;

  // ALU stand-in
  int          stall_cnt = 5;
  int          lat_cnt = 0;
  int          valid_run = 0;
  int          hs_total = 0;
  int          n_drops = 0;
  int          drop_cyc = 0;
  bit          pend = 1'b0;
  bit          first_hs = 1'b1;
  bit          drop_armed = 1'b1;
  logic [31:0] pend_res = '0;
  logic [31:0] last_ret = '0;

  always @(negedge clk) begin : alu_model
    logic [32:0] sp;
    alu_res_valid = 1'b0;
    if (!rst_n) begin
      pend      = 1'b0;
      alu_ready = 1'b0;
      valid_run = 0;
    end else begin
      if (pend) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          pend          = 1'b0;
          alu_res_valid = 1'b1;
          alu_res       = pend_res;
          last_ret      = pend_res;
        end
      end
      if (alu_valid) begin
        valid_run++;
        sp = ref_special(cur_a, cur_b, m_op);
        check("issue_a", alu_a, cur_a);
        check("issue_b", alu_b, cur_b);
        check("issue_op", {30'd0, alu_op}, {30'd0, m_op});
        check("issue_when_bypass", {31'd0, BYP && sp[32]}, 32'd0);
        if (stall_cnt > 0) begin
          alu_ready = 1'b0;
          stall_cnt--;
        end else begin
          alu_ready = 1'b1;
          hs_total++;
          if (first_hs) begin
            check("stalled_valid_cycles", 32'(valid_run), 32'd6);
            first_hs = 1'b0;
          end
          if (drop_armed && m_pair == 4'd1 && m_op == 2'd2) begin
            drop_armed = 1'b0;
            n_drops++;
            drop_cyc = cyc;
          end else begin
            pend     = 1'b1;
            pend_res = alu_fn(alu_a, alu_b, alu_op);
            lat_cnt  = (cur_idx == 2) ? 3 : (m_pair == 4'd5) ? 8 : $urandom_range(1, 5);
          end
          stall_cnt = $urandom_range(0, 2);
        end
      end else begin
        alu_ready = 1'b0;
        valid_run = 0;
      end
    end
  end

  // result checker
  int hs_mark = 0;
  int n_to_seen = 0;
  int n_timeouts = 0;
  int n_run_res = 0;
  int n_done = 0;
  bit done_due = 1'b0;

  always @(negedge clk) begin : res_model
    logic [32:0] sp;
    logic        nan;
    logic [31:0] exp_res;
    logic [2:0]  exp_flags;
    int          exp_hs;
    if (!rst_n) begin
      m_pair    = '0;
      m_op      = '0;
      hs_mark   = hs_total;
      n_to_seen = n_drops;
      n_run_res = 0;
      n_done    = 0;
      done_due  = 1'b0;
    end else begin
      if (done || done_due) check("done_pulse", {31'd0, done}, {31'd0, done_due});
      if (done) n_done++;
      done_due = 1'b0;
      if (res_valid) begin
        sp  = ref_special(cur_a, cur_b, m_op);
        nan = is_nan(cur_a) | is_nan(cur_b);
        if (BYP && sp[32]) begin
          exp_res = sp[31:0]; exp_flags = {nan, 2'b01}; exp_hs = 0;
        end else if (n_drops != n_to_seen) begin
          exp_res = QNAN_C; exp_flags = {nan, 2'b10}; exp_hs = 1;
          check("timeout_cycles", 32'(cyc - drop_cyc), 32'd256);
          n_to_seen = n_drops;
          n_timeouts++;
        end else begin
          exp_res = last_ret; exp_flags = {nan, 2'b00}; exp_hs = 1;
        end
        check("res_out", res_out, exp_res);
        check("res_flags", {29'd0, res_flags}, {29'd0, exp_flags});
        check("res_op", {30'd0, res_op}, {30'd0, m_op});
        check("res_idx", {28'd0, res_idx}, {28'd0, m_pair});
        check("handshakes_per_op", 32'(hs_total - hs_mark), 32'(exp_hs));
        hs_mark = hs_total;
        n_run_res++;
        if (m_op == 2'd3) begin
          m_op = '0;
          if (m_pair == 4'd11) begin
            m_pair   = '0;
            done_due = 1'b1;
          end else begin
            m_pair = m_pair + 4'd1;
          end
        end else begin
          m_op = m_op + 2'd1;
        end
      end
    end
  end

  initial begin
    int lat;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mem_a[i] = rand_normal();
      mem_b[i] = rand_normal();
    end
    mem_a[0]  = 32'h401762B7; mem_b[0]  = 32'h43615EB0;
    mem_a[2]  = 32'h3F800000; mem_b[2]  = 32'h40000000;
    mem_a[3]  = 32'h7F800000; mem_b[3]  = 32'h7FC00000;
    mem_a[7]  = 32'hFF800000; mem_b[7]  = 32'h3F800000;
    mem_a[8]  = 32'h7F800000; mem_b[8]  = 32'h7F800000;
    mem_a[10] = 32'h40912E73; mem_b[10] = 32'h00000000;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'd0, busy, load_data, alu_valid, res_valid, done}, 32'd0);
    check("reset_res_out", res_out, 32'd0);
    check("reset_alu_a", alu_a, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!alu_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_to_issue", 32'(lat), 32'd5);

    guard = 0;
    while (!(m_pair == 4'd5 && pend) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_pair5_wait_res", {31'd0, guard < 20000}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {27'd0, busy, load_data, alu_valid, res_valid, done}, 32'd0);
    check("async_reset_alu", alu_a | alu_b, 32'd0);
    check("async_reset_tags", {21'd0, alu_op, res_op, res_idx, res_flags}, 32'd0);
    check("async_reset_res", res_out, 32'd0);
    check("timeouts_before_reset", 32'(n_timeouts), 32'd1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (m_pair < 4'd2 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (n_done == 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("run_completes", {31'd0, guard < 20000}, 32'd1);
    repeat (5) @(negedge clk);
    check("results_in_run", 32'(n_run_res), 32'd48);
    check("done_pulses", 32'(n_done), 32'd1);
    check("idle_after_run", {30'd0, busy, load_data}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
- Sits between the operand instruction memory and the 32-bit FP ALU.
- Fetches operand pairs by pulsing load_data and capturing A/B after the fixed fetch latency.
- Classifies IEEE-754 specials, then issues ADD, SUB, MUL and DIV for each pair to the ALU over a valid/ready handshake.
- Emits one tagged result per operation. One run covers PAIR_COUNT pairs.

Parameters:
PAIR_COUNT, 12, pairs per run; matches the operand memory wrap point (indices 0..11).
LOAD_WAIT, 2, cycles after the load_data pulse before A/B are captured.
TIMEOUT, 255, maximum cycles waiting for alu_res_valid (8-bit counter).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled in IDLE only
load_data  out  1  one-cycle fetch pulse to the operand memory
a_in  in  32  operand A from memory
b_in  in  32  operand B from memory
alu_a  out  32  operand A to ALU
alu_b  out  32  operand B to ALU
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
alu_valid  out  1  issue request
alu_ready  in  1  ALU accepts
alu_res  in  32  ALU result
alu_res_valid  in  1  result strobe
res_out  out  32  result
res_op  out  2  operation tag
res_idx  out  4  pair index 0..PAIR_COUNT-1
res_flags  out  3  bit0 bypassed, bit1 timeout, bit2 NaN input
res_valid  out  1  one-cycle result strobe; no backpressure
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse after the last result

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0; internal a_q, b_q, pair/op/wait/timeout counters 0.
- IDLE: on start=1, go to LOAD. start in any other state is ignored.
- LOAD: load_data=1 for exactly one cycle, then WAIT. load_data is 0 in every other state, so the memory always sees a clean rising edge.
- WAIT: lasts LOAD_WAIT cycles. On the last one, register a_in/b_in into a_q/b_q and go to CLASSIFY.
- CLASSIFY (1 cycle): decode exp/mantissa of a_q and b_q into nan/inf/zero flags; op=00; go to ISSUE.
- ISSUE:
  - alu_valid=1; alu_a=a_q, alu_b=b_q, alu_op=op, all held stable until alu_ready=1.
  - Handshake completes in a cycle where alu_valid && alu_ready; then alu_valid drops, go to WAIT_RES.
  - Bypass (see Optional Feature): no issue; go straight to EMIT with the special result.
- WAIT_RES:
  - alu_res_valid=1 → latch alu_res, go to EMIT.
  - Timeout counter reaches TIMEOUT → result 0x7FC00000, flags bit1=1, go to EMIT.
  - alu_res_valid arriving in any other state is ignored.
- EMIT (1 cycle): res_valid=1 with res_out/res_op/res_idx/res_flags. flags bit2=1 if either operand is NaN.
  - op<3: op++, go to ISSUE.
  - else if pair==PAIR_COUNT-1: pair=0, done=1, go to IDLE.
  - else: pair++, go to LOAD.
- Latency: first alu_valid is asserted 2+LOAD_WAIT cycles after start is sampled. Each pair produces exactly 4 res_valid pulses, in op order 00,01,10,11.
- Reset mid-operation: immediate return to IDLE; an in-flight ALU result is discarded. The memory index is not resynchronised; a restart continues from the memory's current pointer.

Optional Feature:
SPECIAL_BYPASS_EN
- Defined: in ISSUE, if either operand is NaN, or either is inf for ADD/SUB, or the op is DIV with b zero, skip the ALU. Set flags bit0=1 and produce:
  - NaN input → 0x7FC00000.
  - inf-inf in the effective sense → 0x7FC00000.
  - otherwise inf with the correct sign.
  - DIV x/0 → sign(a)^sign(b) inf, or 0x7FC00000 if a is also zero.
- Undefined: every op goes to the ALU; bit0 is always 0.

Decomposition:
- Package fp_seq_pkg:
  - state enum (IDLE, LOAD, WAIT, CLASSIFY, ISSUE, WAIT_RES, EMIT)
  - op codes
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - flag bit positions
- Sub-module fp_classify: combinational; one 32-bit input; outputs is_nan, is_inf, is_zero, sign. Instantiated for A and B.

Test Plan:
- Pair 2 (3F800000, 40000000), ALU model with 3-cycle result latency → 4 issues with alu_a/alu_b as given and alu_op 0..3; res_idx=2; flags=000.
- alu_ready held low 5 cycles during ADD issue of pair 0 → alu_valid, alu_a=401762B7, alu_b=43615EB0 stable throughout; exactly one handshake.
- SPECIAL_BYPASS_EN, pair 3 (7F800000, 7FC00000) → 4 results of 7FC00000, flags=101, no alu_valid for that pair.
- SPECIAL_BYPASS_EN, pair 10 (40912E73, 00000000) DIV → res_out=7F800000, flags=001; ADD/SUB/MUL go to the ALU.
- ALU never returns a result → after 255 cycles in WAIT_RES, res_out=7FC00000 with flags bit1=1; sequence continues with the next op.
- rst_n low during WAIT_RES of pair 5 → all outputs 0 asynchronously; after release and start, the full run of 48 results ends with a single done pulse.
